// File: rtl/float2fix_pipe_if.sv
// float2fix_pipe_if
//   Streaming bus of the float-to-fixed converter: the operand side
//   (valid_i/ready_o/float_i/rm_i) and the result side
//   (valid_o/ready_i/fix_o/status_o). Signal names are seen from the
//   converter, so "_i" signals are driven by the master and "_o" signals by
//   the converter.
//   Parameter: FIX_LEN - width of fix_o.
//   Modports : slave  - the converter
//              master - the producer/consumer around it (testbench, issue side)
interface float2fix_pipe_if #(
    parameter int FIX_LEN = 64
);
    logic               valid_i;
    logic               ready_o;
    logic [31:0]        float_i;
    logic               rm_i;
    logic               valid_o;
    logic               ready_i;
    logic [FIX_LEN-1:0] fix_o;
    logic [3:0]         status_o;

    modport slave (
        input  valid_i, float_i, rm_i, ready_i,
        output ready_o, valid_o, fix_o, status_o
    );

    modport master (
        output valid_i, float_i, rm_i, ready_i,
        input  ready_o, valid_o, fix_o, status_o
    );
endinterface

// File: rtl/float2fix_pipe.sv
// float2fix_pipe
//   Two-stage pipelined binary32 -> signed fixed-point converter with
//   valid/ready flow control, signed saturation and status flags.
//   Stage 1 decodes the operand and aligns the significand (magnitude,
//   guard, sticky, pre-overflow). Stage 2 rounds, range-checks, applies the
//   sign and forms the flags.
//
//   Parameters: FIX_LEN  - total fixed-point width (16..64)
//               FIX_FRAC - fraction bits (0..FIX_LEN-1)
//   Ports     : clk_i    - clock, rising edge
//               rst_ni   - asynchronous active-low reset
//               io       - float2fix_pipe_if.slave
//                          valid_i/ready_o/float_i/rm_i : operand side
//                          valid_o/ready_i/fix_o        : result side
//                          status_o = {invalid, overflow, underflow, inexact}
//   Macro     : FLOAT2FIX_ROUND_EN - when defined, rm_i=1 selects
//               round-to-nearest-even; otherwise every operand truncates
//               toward zero and rm_i is ignored.
module float2fix_pipe #(
    parameter int FIX_LEN  = 64,
    parameter int FIX_FRAC = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    float2fix_pipe_if.slave io
);

    typedef enum logic [1:0] {
        CLS_ZERO,   // zero or denormal (sticky marks denormal)
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } cls_e;

    // Left-shift work width: 24-bit significand can land anywhere below FIX_LEN.
    localparam int                EXT_W   = FIX_LEN + 24;
    // k = e - 127 + FIX_FRAC - 23
    localparam logic signed [10:0] K_OFS  = 11'(FIX_FRAC - 150);
    localparam logic signed [10:0] K_MAX  = 11'(FIX_LEN);
    localparam logic [FIX_LEN-1:0] SAT_POS = {1'b0, {(FIX_LEN-1){1'b1}}};
    localparam logic [FIX_LEN-1:0] SAT_NEG = {1'b1, {(FIX_LEN-1){1'b0}}};

    // ---------------- pipeline registers ----------------
    logic               v1_q, v1_d;
    logic               sign_q, sign_d;
    cls_e               cls_q, cls_d;
    logic               preovf_q, preovf_d;
    logic [FIX_LEN-1:0] mag_q, mag_d;
    logic               guard_q, guard_d;
    logic               sticky_q, sticky_d;
`ifdef FLOAT2FIX_ROUND_EN
    logic               rm_q, rm_d;
`else
    logic               unused_rm;
    assign unused_rm = io.rm_i;
`endif

    logic               v2_q, v2_d;
    logic [FIX_LEN-1:0] fix_q, fix_d;
    logic [3:0]         status_q, status_d;

    // ---------------- flow control ----------------
    logic adv1, adv2;
    assign adv2 = !v2_q || io.ready_i;
    assign adv1 = !v1_q || adv2;

    assign io.ready_o  = adv1;
    assign io.valid_o  = v2_q;
    assign io.fix_o    = fix_q;
    assign io.status_o = status_q;

    // ---------------- stage 1: decode and align ----------------
    logic [7:0]         exp_w;
    logic [22:0]        man_w;
    logic [23:0]        sig_w;
    logic signed [10:0] k_w;
    logic signed [10:0] n_w;
    logic [EXT_W-1:0]   lsh_w;
    logic [47:0]        rsh_w;
    logic [EXT_W-1:0]   rext_w;
    cls_e               dec_cls;
    logic               dec_pov;
    logic [FIX_LEN-1:0] dec_mag;
    logic               dec_guard;
    logic               dec_sticky;

    // NOTE: every signal written in an always_comb gets a default at the top
    // of the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin : decode
        exp_w      = io.float_i[30:23];
        man_w      = io.float_i[22:0];
        sig_w      = {1'b1, man_w};
        k_w        = $signed({3'b000, exp_w}) + K_OFS;
        n_w        = -k_w;
        lsh_w      = EXT_W'(sig_w) << k_w[6:0];
        // Significand followed by 24 zero bits: after the right shift the
        // top half is the integer magnitude, bit 23 the guard, the rest sticky.
        rsh_w      = {sig_w, 24'h0} >> n_w[4:0];
        rext_w     = EXT_W'(rsh_w[47:24]);
        dec_cls    = CLS_ZERO;
        dec_pov    = 1'b0;
        dec_mag    = '0;
        dec_guard  = 1'b0;
        dec_sticky = 1'b0;

        if (exp_w == 8'hFF) begin
            dec_cls = (man_w != '0) ? CLS_NAN : CLS_INF;
        end else if (exp_w == 8'h00) begin
            // Denormals are far below one fixed-point LSB: all bits are
            // sticky and the guard stays clear, so RNE can never round up.
            dec_cls    = CLS_ZERO;
            dec_sticky = (man_w != '0);
        end else begin
            dec_cls = CLS_NORM;
            if (!k_w[10]) begin
                if (k_w >= K_MAX) begin
                    dec_pov = 1'b1;
                end else begin
                    dec_pov = |lsh_w[EXT_W-1:FIX_LEN];
                    dec_mag = lsh_w[FIX_LEN-1:0];
                end
            end else if (n_w > 11'sd24) begin
                // Shift saturates: even the leading one lies below the guard.
                dec_sticky = 1'b1;
            end else begin
                // Narrow FIX_LEN can still overflow on a small right shift.
                dec_pov    = |rext_w[EXT_W-1:FIX_LEN];
                dec_mag    = rext_w[FIX_LEN-1:0];
                dec_guard  = rsh_w[23];
                dec_sticky = |rsh_w[22:0];
            end
        end
    end

    always_comb begin : stage1_next
        v1_d     = v1_q;
        sign_d   = sign_q;
        cls_d    = cls_q;
        preovf_d = preovf_q;
        mag_d    = mag_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
`ifdef FLOAT2FIX_ROUND_EN
        rm_d     = rm_q;
`endif
        if (adv1) begin
            v1_d = io.valid_i;
            if (io.valid_i) begin
                sign_d   = io.float_i[31];
                cls_d    = dec_cls;
                preovf_d = dec_pov;
                mag_d    = dec_mag;
                guard_d  = dec_guard;
                sticky_d = dec_sticky;
`ifdef FLOAT2FIX_ROUND_EN
                rm_d     = io.rm_i;
`endif
            end
        end
    end

    // ---------------- stage 2: round, range check, sign ----------------
    logic               inc_w;
    logic [FIX_LEN:0]   sum_w;
    logic [FIX_LEN-1:0] rmag_w;
    logic               over_w;
    logic               nonzero_w;
    logic               uflow_w;
    logic [FIX_LEN-1:0] res_fix;
    logic [3:0]         res_status;

    always_comb begin : stage2_calc
        inc_w = 1'b0;
`ifdef FLOAT2FIX_ROUND_EN
        inc_w = rm_q && guard_q && (sticky_q || mag_q[0]);
`endif
        // Round the magnitude; the carry out of the top is kept for the check.
        sum_w  = {1'b0, mag_q} + {{FIX_LEN{1'b0}}, inc_w};
        rmag_w = sum_w[FIX_LEN-1:0];
        // Negative side admits exactly 2^(FIX_LEN-1); positive side does not.
        over_w = preovf_q || sum_w[FIX_LEN] ||
                 (sign_q ? (rmag_w[FIX_LEN-1] && (|rmag_w[FIX_LEN-2:0]))
                         : rmag_w[FIX_LEN-1]);
        nonzero_w  = (cls_q == CLS_NORM) || sticky_q;
        uflow_w    = nonzero_w && (rmag_w == '0);
        res_fix    = '0;
        res_status = 4'b0000;

        if (cls_q == CLS_NAN) begin
            res_status = 4'b1000;
        end else if ((cls_q == CLS_INF) || over_w) begin
            res_fix    = sign_q ? SAT_NEG : SAT_POS;
            res_status = 4'b0100;
        end else begin
            res_fix    = sign_q ? -rmag_w : rmag_w;
            res_status = {2'b00, uflow_w, uflow_w || guard_q || sticky_q};
        end
    end

    always_comb begin : stage2_next
        v2_d     = v2_q;
        fix_d    = fix_q;
        status_d = status_q;
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                fix_d    = res_fix;
                status_d = res_status;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    // NOTE: data registers are reset as well as the valids, so fix_o and
    // status_o read 0 straight after reset rather than stale values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q     <= 1'b0;
            sign_q   <= 1'b0;
            cls_q    <= CLS_ZERO;
            preovf_q <= 1'b0;
            mag_q    <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
`ifdef FLOAT2FIX_ROUND_EN
            rm_q     <= 1'b0;
`endif
            v2_q     <= 1'b0;
            fix_q    <= '0;
            status_q <= '0;
        end else begin
            v1_q     <= v1_d;
            sign_q   <= sign_d;
            cls_q    <= cls_d;
            preovf_q <= preovf_d;
            mag_q    <= mag_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
`ifdef FLOAT2FIX_ROUND_EN
            rm_q     <= rm_d;
`endif
            v2_q     <= v2_d;
            fix_q    <= fix_d;
            status_q <= status_d;
        end
    end

endmodule

// File: tb/tb_float2fix_pipe.sv
// tb_float2fix_pipe
//   Directed bench for float2fix_pipe (FIX_LEN=64, FIX_FRAC=32). Expected
//   results are queued when an operand is accepted and compared by a monitor
//   when the converter delivers a result. Inputs change 1 time unit after the
//   rising edge; outputs are sampled on the falling edge.
module tb_float2fix_pipe;

    localparam int FIX_LEN  = 64;
    localparam int FIX_FRAC = 32;

    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MAXN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONE  = 64'h0000_0001_0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    float2fix_pipe_if #(.FIX_LEN(FIX_LEN)) bus ();

    float2fix_pipe #(
        .FIX_LEN (FIX_LEN),
        .FIX_FRAC(FIX_FRAC)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .io    (bus)
    );

    typedef struct packed {
        logic [63:0] fix;
        logic [3:0]  st;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_out = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand, wait (bounded) for acceptance, record its expected result.
    task automatic send(input logic [31:0] f, input logic rm,
                        input logic [63:0] ef, input logic [3:0] es);
        int waited;
        waited      = 0;
        bus.valid_i = 1'b1;
        bus.float_i = f;
        bus.rm_i    = rm;
        #1;
        while (!bus.ready_o && waited < 50) begin
            tick();
            waited++;
        end
        check("send_accept", 64'(bus.ready_o), 64'd1);
        if (bus.ready_o) sb.push_back(exp_t'{ef, es});
        tick();
        bus.valid_i = 1'b0;
    endtask

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.valid_o && bus.ready_i) begin
            n_cmp++;
            assert (sb.size() != 0)
            else begin
                n_err++;
                $error("FAIL out_unexpected: observed %h expected no result", bus.fix_o);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_fix", bus.fix_o, e.fix);
                check("out_status", 64'(bus.status_o), 64'(e.st));
            end
            n_out++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.valid_i = 1'b0;
        bus.float_i = '0;
        bus.rm_i    = 1'b0;
        bus.ready_i = 1'b1;

        // Reset state
        #12;
        check("rst_valid_o", 64'(bus.valid_o), 64'd0);
        check("rst_fix_o", bus.fix_o, 64'd0);
        check("rst_status_o", 64'(bus.status_o), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_ready_o", 64'(bus.ready_o), 64'd1);

        // Latency: 1.0 -> valid_o in the second cycle after the transfer
        send(32'h3F80_0000, 1'b0, ONE, 4'b0000);
        check("lat_cycle1_valid", 64'(bus.valid_o), 64'd0);
        tick();
        check("lat_cycle2_valid", 64'(bus.valid_o), 64'd1);
        check("lat_cycle2_fix", bus.fix_o, ONE);
        repeat (3) tick();

        // Streaming directed operands
        send(32'hC020_0000, 1'b0, 64'hFFFF_FFFD_8000_0000, 4'b0000); // -2.5
        send(32'h4F00_0000, 1'b0, MAXP, 4'b0100);                    // 2^31
        send(32'hCF00_0000, 1'b0, MAXN, 4'b0000);                    // -2^31
        send(32'hFF80_0000, 1'b0, MAXN, 4'b0100);                    // -inf
        send(32'h7F80_0000, 1'b0, MAXP, 4'b0100);                    // +inf
        send(32'h2F40_0000, 1'b0, 64'd0, 4'b0011);                   // 1.5*2^-33 RTZ
        send(32'hAF40_0000, 1'b0, 64'd0, 4'b0011);                   // -1.5*2^-33 RTZ
        send(32'h7FC0_0000, 1'b0, 64'd0, 4'b1000);                   // NaN
        send(32'h8000_0000, 1'b0, 64'd0, 4'b0000);                   // -0
        send(32'h0000_0001, 1'b0, 64'd0, 4'b0011);                   // denormal
        send(32'h0000_0001, 1'b1, 64'd0, 4'b0011);                   // denormal, RNE
        send(32'h2FC0_0000, 1'b0, 64'd1, 4'b0001);                   // 1.5 LSB RTZ
        send(32'h4EFF_FFFF, 1'b0, 64'h7FFF_FF80_0000_0000, 4'b0000); // 2^31-128
        send(32'h5F00_0000, 1'b0, MAXP, 4'b0100);                    // 2^63, shift saturates
        send(32'h0D80_0000, 1'b0, 64'd0, 4'b0011);                   // 2^-100
`ifdef FLOAT2FIX_ROUND_EN
        send(32'h2F40_0000, 1'b1, 64'd1, 4'b0001);                   // 0.75 LSB RNE up
        send(32'h2FC0_0000, 1'b1, 64'd2, 4'b0001);                   // 1.5 LSB RNE to even
        send(32'h2F00_0000, 1'b1, 64'd0, 4'b0011);                   // 0.5 LSB RNE tie to 0
`else
        send(32'h2F40_0000, 1'b1, 64'd0, 4'b0011);
        send(32'h2FC0_0000, 1'b1, 64'd1, 4'b0001);
        send(32'h2F00_0000, 1'b1, 64'd0, 4'b0011);
`endif
        repeat (4) tick();
        check("stream_drained", 64'(sb.size()), 64'd0);

        // Stall: 1.0, 2.0 fill the pipe while ready_i=0, then 3.0 on release
        base = n_out;
        send(32'h3F80_0000, 1'b0, ONE, 4'b0000);
        bus.ready_i = 1'b0;
        #1;
        send(32'h4000_0000, 1'b0, 64'h0000_0002_0000_0000, 4'b0000);
        check("stall_ready_o", 64'(bus.ready_o), 64'd0);
        check("stall_valid_o", 64'(bus.valid_o), 64'd1);
        check("stall_fix_0", bus.fix_o, ONE);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_fix_hold", bus.fix_o, ONE);
            check("stall_ready_low", 64'(bus.ready_o), 64'd0);
        end
        bus.ready_i = 1'b1;
        #1;
        check("release_ready_o", 64'(bus.ready_o), 64'd1);
        send(32'h4040_0000, 1'b0, 64'h0000_0003_0000_0000, 4'b0000);
        check("release_valid_c1", 64'(bus.valid_o), 64'd1);
        tick();
        check("release_valid_c2", 64'(bus.valid_o), 64'd1);
        repeat (3) tick();
        check("stall_out_count", 64'(n_out - base), 64'd3);

        // Reset with both stages full
        bus.ready_i = 1'b0;
        #1;
        send(32'hFF80_0000, 1'b0, MAXN, 4'b0100);
        send(32'h3F80_0000, 1'b0, ONE, 4'b0000);
        check("prerst_fix", bus.fix_o, MAXN);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("midrst_valid_o", 64'(bus.valid_o), 64'd0);
        check("midrst_fix_o", bus.fix_o, 64'd0);
        check("midrst_status_o", 64'(bus.status_o), 64'd0);
        tick();
        rst_n       = 1'b1;
        bus.ready_i = 1'b1;
        tick();
        check("postrst_ready_o", 64'(bus.ready_o), 64'd1);
        base = n_out;
        send(32'h3F80_0000, 1'b0, ONE, 4'b0000);
        check("postrst_c1_valid", 64'(bus.valid_o), 64'd0);
        repeat (5) tick();
        check("postrst_out_count", 64'(n_out - base), 64'd1);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
